// File: rtl/bnn_inference_sequencer.sv
// Sequences one BNN inference per accepted request: arm, run under a watchdog,
// capture the class, clear the image buffer and BNN, then return to idle.
module bnn_inference_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       abort,
  input  logic       buffer_full,
  input  logic       bnn_ready_for_input,
  input  logic       bnn_result_ready,
  input  logic [3:0] bnn_result,
  input  logic       clear_done,
  output logic       bnn_enable,
  output logic       clear_req,
  output logic       result_valid,
  output logic [3:0] result_out,
  output logic       busy,
  output logic       error,
  output logic [2:0] state_code,
  output logic [7:0] infer_count
);

  localparam int unsigned CLS_W   = 4;
  localparam int unsigned ICNT_W  = 8;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_CLEAR   = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic [CLS_W-1:0]    hold_q, hold_d;
  logic [CLS_W-1:0]    result_out_q, result_out_d;
  logic                result_valid_q, result_valid_d;
  logic [ICNT_W-1:0]   infer_count_q, infer_count_d;
  logic                error_q, error_d;
  logic                bnn_enable_q, bnn_enable_d;
  logic                clear_req_q, clear_req_d;
  logic                busy_q, busy_d;
  logic                wd_expired;
  logic                in_clear_phase;

  assign wd_expired     = (wd_q == WD_LAST);
  assign in_clear_phase = (state_q == S_CLEAR) || (state_q == S_FAULT);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      hold_q         <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
      infer_count_q  <= '0;
      error_q        <= 1'b0;
      bnn_enable_q   <= 1'b0;
      clear_req_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      hold_q         <= hold_d;
      result_out_q   <= result_out_d;
      result_valid_q <= result_valid_d;
      infer_count_q  <= infer_count_d;
      error_q        <= error_d;
      bnn_enable_q   <= bnn_enable_d;
      clear_req_q    <= clear_req_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    result_out_d   = result_out_q;
    result_valid_d = result_valid_q;
    infer_count_d  = infer_count_q;
    error_d        = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_req && buffer_full && bnn_ready_for_input) begin
          state_d        = S_ARM;
          error_d        = 1'b0;
          result_valid_d = 1'b0;
        end
      end
      S_ARM: begin
        state_d = abort ? S_FAULT : S_RUN;
      end
      S_RUN: begin
        // abort beats a same-cycle result; a result beats a same-cycle timeout
        if (abort) begin
          state_d = S_FAULT;
        end else if (bnn_result_ready) begin
          state_d = S_CAPTURE;
          hold_d  = bnn_result;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_FAULT;
        end else begin
          state_d        = S_CLEAR;
          result_out_d   = hold_q;
          result_valid_d = 1'b1;
          infer_count_d  = infer_count_q + ICNT_W'(1);
        end
      end
      S_CLEAR: begin
        if (clear_done) begin
          state_d = S_IDLE;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (clear_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_FAULT) begin
      error_d = 1'b1;
    end

    // Watchdog runs only in RUN and CLEAR; ARM and CAPTURE leave it at zero for the next phase
    wd_d = ((state_q == S_RUN) || (state_q == S_CLEAR)) ? wd_q + CNT_W'(1) : '0;

    bnn_enable_d = (state_d == S_ARM) || (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
    // clear_req rises the cycle after CLEAR/FAULT entry and drops once clear_done is seen
    clear_req_d  = in_clear_phase && (state_d != S_IDLE);
  end

  assign bnn_enable   = bnn_enable_q;
  assign clear_req    = clear_req_q;
  assign result_valid = result_valid_q;
  assign result_out   = result_out_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign state_code   = state_q;
  assign infer_count  = infer_count_q;

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// Randomized job-level bench for bnn_inference_sequencer against a transaction model.
module tb_bnn_inference_sequencer;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_req, abort, buffer_full, bnn_ready_for_input;
  logic       bnn_result_ready, clear_done;
  logic [3:0] bnn_result;
  logic       bnn_enable, clear_req, result_valid, busy, error;
  logic [3:0] result_out;
  logic [2:0] state_code;
  logic [7:0] infer_count;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Job-level model of the visible results
  logic [7:0] exp_cnt;
  logic       exp_valid;
  logic [3:0] exp_res;
  logic       exp_err;

  bnn_inference_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_req           (start_req),
    .abort               (abort),
    .buffer_full         (buffer_full),
    .bnn_ready_for_input (bnn_ready_for_input),
    .bnn_result_ready    (bnn_result_ready),
    .bnn_result          (bnn_result),
    .clear_done          (clear_done),
    .bnn_enable          (bnn_enable),
    .clear_req           (clear_req),
    .result_valid        (result_valid),
    .result_out          (result_out),
    .busy                (busy),
    .error               (error),
    .state_code          (state_code),
    .infer_count         (infer_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".state"},  32'(state_code), 32'd0);
    check_eq({tag, ".busy"},   32'(busy), 32'd0);
    check_eq({tag, ".en"},     32'(bnn_enable), 32'd0);
    check_eq({tag, ".clr"},    32'(clear_req), 32'd0);
    check_eq({tag, ".cnt"},    32'(infer_count), 32'(exp_cnt));
    check_eq({tag, ".valid"},  32'(result_valid), 32'(exp_valid));
    check_eq({tag, ".res"},    32'(result_out), 32'(exp_res));
    check_eq({tag, ".err"},    32'(error), 32'(exp_err));
  endtask

  // Called in the first FAULT cycle; holds clear_done off a while then releases
  task automatic fault_tail();
    int unsigned w;
    exp_err = 1'b1;
    check_eq("fault.state", 32'(state_code), 32'd5);
    check_eq("fault.err",   32'(error), 32'd1);
    check_eq("fault.en",    32'(bnn_enable), 32'd0);
    check_eq("fault.busy",  32'(busy), 32'd1);
    check_eq("fault.valid", 32'(result_valid), 32'(exp_valid));
    step();
    w = $urandom_range(0, 5);
    for (int i = 0; i < int'(w); i++) begin
      check_eq("fault.hold", 32'(state_code), 32'd5);
      check_eq("fault.clr",  32'(clear_req), 32'd1);
      check_eq("fault.en0",  32'(bnn_enable), 32'd0);
      abort = ($urandom_range(0, 2) == 0);
      step();
      abort = 1'b0;
    end
    clear_done = 1'b1;
    check_eq("fault.clr_last", 32'(clear_req), 32'd1);
    step();
    clear_done = 1'b0;
    check_idle("fault.done");
  endtask

  // mode: 0 normal, 1 run timeout, 2 abort in ARM, 3 abort in RUN (with result),
  //       4 abort in CAPTURE, 5 clear timeout
  task automatic run_job(input int mode, input int k, input logic [3:0] cls, input int c);
    int nrun;
    buffer_full         = 1'b1;
    bnn_ready_for_input = 1'b1;
    start_req           = 1'b1;
    check_eq("job.idle", 32'(state_code), 32'd0);
    step();
    start_req = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    check_eq("arm.state", 32'(state_code), 32'd1);
    check_eq("arm.en",    32'(bnn_enable), 32'd1);
    check_eq("arm.valid", 32'(result_valid), 32'd0);
    check_eq("arm.err",   32'(error), 32'd0);
    if (mode == 2) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      fault_tail();
      return;
    end
    step();
    nrun = (mode == 1) ? int'(TO) : k;
    for (int i = 0; i < nrun; i++) begin
      check_eq("run.state", 32'(state_code), 32'd2);
      check_eq("run.en",    32'(bnn_enable), 32'd1);
      check_eq("run.clr",   32'(clear_req), 32'd0);
      start_req = ($urandom_range(0, 3) == 0);
      step();
      start_req = 1'b0;
    end
    if (mode == 1) begin
      fault_tail();
      return;
    end
    check_eq("res.state", 32'(state_code), 32'd2);
    check_eq("res.en",    32'(bnn_enable), 32'd1);
    bnn_result_ready = 1'b1;
    bnn_result       = cls;
    abort            = (mode == 3);
    step();
    bnn_result_ready = 1'b0;
    abort            = 1'b0;
    bnn_result       = 4'($urandom);
    if (mode == 3) begin
      fault_tail();
      return;
    end
    check_eq("cap.state", 32'(state_code), 32'd3);
    check_eq("cap.en",    32'(bnn_enable), 32'd0);
    check_eq("cap.valid", 32'(result_valid), 32'd0);
    abort = (mode == 4);
    step();
    abort = 1'b0;
    if (mode == 4) begin
      fault_tail();
      return;
    end
    exp_valid = 1'b1;
    exp_res   = cls;
    exp_cnt   = exp_cnt + 8'd1;
    check_eq("clr.state", 32'(state_code), 32'd4);
    check_eq("clr.valid", 32'(result_valid), 32'd1);
    check_eq("clr.res",   32'(result_out), 32'(cls));
    check_eq("clr.cnt",   32'(infer_count), 32'(exp_cnt));
    check_eq("clr.req0",  32'(clear_req), 32'd0);
    step();
    if (mode == 5) begin
      for (int i = 0; i < int'(TO) - 1; i++) begin
        check_eq("clrto.state", 32'(state_code), 32'd4);
        check_eq("clrto.req",   32'(clear_req), 32'd1);
        step();
      end
      fault_tail();
      return;
    end
    for (int i = 0; i < c; i++) begin
      check_eq("clr.hold", 32'(state_code), 32'd4);
      check_eq("clr.req",  32'(clear_req), 32'd1);
      check_eq("clr.en0",  32'(bnn_enable), 32'd0);
      step();
    end
    clear_done = 1'b1;
    check_eq("clr.req_last", 32'(clear_req), 32'd1);
    step();
    clear_done = 1'b0;
    check_idle("job.done");
  endtask

  task automatic rejected_start();
    int unsigned sel;
    sel = $urandom_range(0, 2);
    buffer_full         = (sel == 1);
    bnn_ready_for_input = (sel == 2);
    start_req           = 1'b1;
    abort               = ($urandom_range(0, 1) == 0);
    step();
    start_req = 1'b0;
    abort     = 1'b0;
    check_idle("reject");
  endtask

  task automatic model_reset();
    exp_cnt   = 8'd0;
    exp_valid = 1'b0;
    exp_res   = 4'd0;
    exp_err   = 1'b0;
  endtask

  initial begin
    int mode;
    rst_n = 1'b0;
    start_req = 1'b0; abort = 1'b0; buffer_full = 1'b0; bnn_ready_for_input = 1'b0;
    bnn_result_ready = 1'b0; bnn_result = 4'd0; clear_done = 1'b0;
    model_reset();
    step();
    step();
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Nominal job: result at T+5, clear_done at T+9
    run_job(0, 3, 4'd7, 1);
    rejected_start();
    run_job(1, 0, 4'd0, 0);
    run_job(0, int'(TO) - 1, 4'd12, 2);
    run_job(3, 4, 4'd9, 0);
    run_job(2, 0, 4'd0, 0);
    run_job(4, 2, 4'd5, 0);
    run_job(5, 1, 4'd15, 0);
    run_job(0, 0, 4'd1, 0);

    for (int n = 0; n < 200; n++) begin
      mode = int'($urandom_range(0, 9));
      if (mode >= 6) begin
        if (mode == 9) rejected_start();
        mode = 0;
      end
      run_job(mode, int'($urandom_range(0, TO - 1)), 4'($urandom), int'($urandom_range(0, 10)));
    end

    // Asynchronous reset in the middle of RUN
    run_job(0, 1, 4'd3, 0);
    buffer_full = 1'b1; bnn_ready_for_input = 1'b1; start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    step();
    check_eq("prerst.state", 32'(state_code), 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("postrst");

    // Counter wrap over 256 completed jobs
    for (int n = 0; n < 256; n++) begin
      run_job(0, int'($urandom_range(0, 3)), 4'($urandom), int'($urandom_range(0, 2)));
    end
    check_eq("wrap.cnt", 32'(infer_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
